// File: rtl/fadd_pipe.sv
// fadd_pipe: 3-stage IEEE-754 binary32 adder/subtractor with a pass-through tag.
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
// A producer holds its payload stable until that edge. in_ready never looks at
// in_valid, and out_valid never looks at out_ready.
module fadd_pipe #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic             op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [31:0] QNAN = 32'h7fc00000;

  // Highest set bit position counted from bit 27; 28 when the vector is zero.
  function automatic logic [4:0] lzc28(input logic [27:0] v);
    lzc28 = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (v[i]) lzc28 = 5'(27 - i);
    end
  endfunction

  logic s1_adv, s2_adv, s3_adv;

  // Stage 1 registers and next-state values
  logic v1_q, sgn1_q, sub1_q, zsgn1_q, spec1_q;
  logic [7:0] exp1_q;
  logic [26:0] ma1_q, mb1_q;
  logic [31:0] sy1_q;
  logic [TAG_W-1:0] tag1_q;
  logic sgn1_d, sub1_d, zsgn1_d, spec1_d;
  logic [7:0] exp1_d;
  logic [26:0] ma1_d, mb1_d;
  logic [31:0] sy1_d;

  // Stage 2 registers and next-state values
  logic v2_q, sgn2_q, zsgn2_q, spec2_q;
  logic [7:0] exp2_q;
  logic [27:0] sum2_q, sum2_d;
  logic [4:0] lzc2_q, lzc2_d;
  logic [31:0] sy2_q;
  logic [TAG_W-1:0] tag2_q;

  // Stage 3 (output) registers and next-state values
  logic v3_q, ovf3_q, ovf3_d;
  logic [31:0] y3_q, y3_d;
  logic [TAG_W-1:0] tag3_q;

  // S1 working signals
  logic sb_eff, swap, nan_in, inf_a, inf_b, sa, sb;
  logic [7:0] ea, eb, ee_a, ee_b, diff;
  logic [22:0] fa, fb;
  logic [23:0] mb;
  logic [26:0] mbx, mask;
  logic [4:0] sh;

  // S3 working signals
  logic [4:0] lz, shamt;
  logic [7:0] emax, e8;
  logic [8:0] exp9;
  logic [26:0] norm;
  logic rnd_up, big;
  logic [30:0] rnd;

  // A stage moves forward when it is empty or its successor makes room.
  always_comb begin
    s3_adv   = !v3_q || out_ready;
    s2_adv   = !v2_q || s3_adv;
    s1_adv   = !v1_q || s2_adv;
    in_ready = s1_adv;
  end

  // S1: unpack, classify specials, order by magnitude, align the smaller operand.
  always_comb begin
    sb_eff  = x2[31] ^ op;
    swap    = x2[30:0] > x1[30:0];
    sa      = swap ? sb_eff : x1[31];
    sb      = swap ? x1[31] : sb_eff;
    ea      = swap ? x2[30:23] : x1[30:23];
    eb      = swap ? x1[30:23] : x2[30:23];
    fa      = swap ? x2[22:0] : x1[22:0];
    fb      = swap ? x1[22:0] : x2[22:0];
    ee_a    = (ea == 8'd0) ? 8'd1 : ea;
    ee_b    = (eb == 8'd0) ? 8'd1 : eb;
    mb      = {eb != 8'd0, fb};
    diff    = ee_a - ee_b;
    mbx     = {mb, 3'b000};
    sh      = diff[4:0];
    mask    = (27'd1 << sh) - 27'd1;
    if (diff >= 8'd26) mb1_d = {26'b0, |mb};
    else               mb1_d = (mbx >> sh) | {26'b0, |(mbx & mask)};
    ma1_d   = {ea != 8'd0, fa, 3'b000};
    exp1_d  = ee_a;
    sgn1_d  = sa;
    sub1_d  = sa ^ sb;
    zsgn1_d = x1[31] & sb_eff;
    nan_in  = ((x1[30:23] == 8'hff) && (x1[22:0] != 23'd0)) ||
              ((x2[30:23] == 8'hff) && (x2[22:0] != 23'd0));
    inf_a   = (x1[30:23] == 8'hff);
    inf_b   = (x2[30:23] == 8'hff);
    spec1_d = nan_in || inf_a || inf_b;
    if (nan_in || (inf_a && inf_b && (x1[31] != sb_eff))) sy1_d = QNAN;
    else if (inf_a)                                       sy1_d = {x1[31], 8'hff, 23'd0};
    else                                                  sy1_d = {sb_eff, 8'hff, 23'd0};
  end

  // S1 register: capture a new operation whenever the stage advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0; sgn1_q <= 1'b0; sub1_q <= 1'b0; zsgn1_q <= 1'b0; spec1_q <= 1'b0;
      exp1_q <= '0; ma1_q <= '0; mb1_q <= '0; sy1_q <= '0; tag1_q <= '0;
    end else if (s1_adv) begin
      v1_q <= in_valid;
      if (in_valid) begin
        sgn1_q <= sgn1_d; sub1_q <= sub1_d; zsgn1_q <= zsgn1_d; spec1_q <= spec1_d;
        exp1_q <= exp1_d; ma1_q <= ma1_d; mb1_q <= mb1_d; sy1_q <= sy1_d; tag1_q <= in_tag;
      end
    end
  end

  // S2: magnitude add or subtract (never negative after the swap) and leading-zero count.
  always_comb begin
    if (sub1_q) sum2_d = {1'b0, ma1_q} - {1'b0, mb1_q};
    else        sum2_d = {1'b0, ma1_q} + {1'b0, mb1_q};
    lzc2_d = lzc28(sum2_d);
  end

  // S2 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q <= 1'b0; sgn2_q <= 1'b0; zsgn2_q <= 1'b0; spec2_q <= 1'b0;
      exp2_q <= '0; sum2_q <= '0; lzc2_q <= '0; sy2_q <= '0; tag2_q <= '0;
    end else if (s2_adv) begin
      v2_q <= v1_q;
      if (v1_q) begin
        sgn2_q <= sgn1_q; zsgn2_q <= zsgn1_q; spec2_q <= spec1_q;
        exp2_q <= exp1_q; sum2_q <= sum2_d; lzc2_q <= lzc2_d; sy2_q <= sy1_q; tag2_q <= tag1_q;
      end
    end
  end

  // S3: normalise without letting the exponent fall below 1, round to nearest even, repack.
  always_comb begin
    lz    = lzc2_q - 5'd1;
    emax  = exp2_q - 8'd1;
    shamt = ({3'b000, lz} < emax) ? lz : emax[4:0];
    if (sum2_q[27]) begin
      norm = {sum2_q[27:2], sum2_q[1] | sum2_q[0]};
      exp9 = {1'b0, exp2_q} + 9'd1;
    end else begin
      norm = sum2_q[26:0] << shamt;
      exp9 = {1'b0, exp2_q} - {4'b0000, shamt};
    end
    // A clear hidden bit after normalisation means a subnormal result (field 0).
    e8     = norm[26] ? exp9[7:0] : 8'd0;
    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    // Rounding carry ripples into the exponent field, covering subnormal->normal and ->inf.
    rnd    = {e8, norm[25:3]} + {30'b0, rnd_up};
    big    = (exp9 >= 9'd255) || (rnd[30:23] == 8'hff);
    y3_d   = {sgn2_q, rnd};
    ovf3_d = 1'b0;
    if (spec2_q) begin
      y3_d = sy2_q;
    end else if (sum2_q == 28'd0) begin
      y3_d = {zsgn2_q, 31'd0};
    end else if (big) begin
      y3_d   = {sgn2_q, 8'hff, 23'd0};
      ovf3_d = 1'b1;
    end
  end

  // S3 register drives the outputs and holds them while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_q <= 1'b0; y3_q <= '0; ovf3_q <= 1'b0; tag3_q <= '0;
    end else if (s3_adv) begin
      v3_q <= v2_q;
      if (v2_q) begin
        y3_q <= y3_d; ovf3_q <= ovf3_d; tag3_q <= tag2_q;
      end
    end
  end

  assign out_valid = v3_q;
  assign y         = y3_q;
  assign ovf       = ovf3_q;
  assign out_tag   = tag3_q;

endmodule

// File: tb/tb_fadd_pipe.sv
// Bench for fadd_pipe: directed vector table, backpressure sequence, random traffic
// against a real-arithmetic reference model, and a mid-stream reset.
module tb_fadd_pipe;
  localparam int TAG_W = 5;
  localparam int W = 32 + 1 + TAG_W;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, op, out_valid, out_ready, ovf;
  logic [31:0] x1, x2, y;
  logic [TAG_W-1:0] in_tag, out_tag;

  fadd_pipe #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .op(op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf), .out_tag(out_tag)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  bit sb_en = 1'b0;
  int popped = 0;

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] x1;
    logic [31:0] x2;
    logic        op;
    logic [31:0] y;
    logic        ovf;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  // ---------------- reference model (real arithmetic) ----------------
  function automatic real pow2(input int e);
    real p;
    p = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) p = p * 2.0;
    else        for (int i = 0; i < -e; i++) p = p / 2.0;
    return p;
  endfunction

  function automatic real to_real(input logic [31:0] b);
    int unsigned fi;
    int ex;
    real v;
    fi = {9'd0, b[22:0]};
    ex = {24'd0, b[30:23]};
    if (ex == 0) v = real'(fi) * pow2(-149);
    else         v = (real'(fi) + 8388608.0) * pow2(ex - 150);
    return b[31] ? -v : v;
  endfunction

  // Nonzero real -> {binary32, ovf}, rounded to nearest even.
  function automatic logic [32:0] encode(input real s);
    logic sg;
    real v, p, q, fr;
    int e, ip, ex;
    logic [31:0] fbits;
    sg = (s < 0.0);
    v = sg ? -s : s;
    e = 0; p = 1.0;
    while (p * 2.0 <= v) begin p = p * 2.0; e++; end
    while (p > v) begin p = p / 2.0; e--; end
    if (e < -126) e = -126;
    q = v / pow2(e - 23);
    ip = $rtoi(q);
    fr = q - real'(ip);
    if (fr > 0.5 || (fr == 0.5 && (ip % 2) == 1)) ip++;
    if (ip == (1 << 24)) begin ip = 1 << 23; e++; end
    if (e > 127) return {sg, 8'hff, 23'd0, 1'b1};
    ex = (ip < (1 << 23)) ? 0 : e + 127;
    fbits = ip % (1 << 23);
    return {sg, 8'(ex), fbits[22:0], 1'b0};
  endfunction

  function automatic logic [32:0] model(input logic [31:0] a_in, input logic [31:0] b_in, input logic o);
    logic [31:0] a, b;
    logic nan_a, nan_b, inf_a, inf_b;
    real s;
    a = a_in;
    b = {b_in[31] ^ o, b_in[30:0]};
    nan_a = (a[30:23] == 8'hff) && (a[22:0] != 0);
    nan_b = (b[30:23] == 8'hff) && (b[22:0] != 0);
    inf_a = (a[30:23] == 8'hff) && !nan_a;
    inf_b = (b[30:23] == 8'hff) && !nan_b;
    if (nan_a || nan_b) return {32'h7fc00000, 1'b0};
    if (inf_a && inf_b) return (a[31] == b[31]) ? {a, 1'b0} : {32'h7fc00000, 1'b0};
    if (inf_a) return {a, 1'b0};
    if (inf_b) return {b, 1'b0};
    s = to_real(a) + to_real(b);
    if (s == 0.0) return {a[31] & b[31], 31'd0, 1'b0};
    return encode(s);
  endfunction

  // ---------------- driver / scoreboard ----------------
  // One cycle: inputs already driven just after the previous rising edge; sample at the
  // falling edge (values that the next rising edge will use), then advance.
  task automatic step(output bit acc, output bit rdy);
    @(negedge clk);
    acc = in_valid && in_ready;
    rdy = in_ready;
    if (sb_en) begin
      if (acc) exp_q.push_back({model(x1, x2, op), in_tag});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_stray_output", {63'd0, out_valid}, 64'd0);
        end else begin
          chk("sb_result", {26'd0, y, ovf, out_tag}, {26'd0, exp_q[0]});
          if (out_ready) begin
            void'(exp_q.pop_front());
            popped++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic gen_op(output logic [31:0] a, output logic [31:0] b, output logic o);
    int k;
    logic [31:0] sp[6];
    sp = '{32'h00000000, 32'h80000000, 32'h7f800000, 32'hff800000, 32'h7fc12345, 32'h7f7fffff};
    k = $urandom_range(0, 7);
    a = $urandom;
    b = $urandom;
    o = 1'($urandom_range(0, 1));
    case (k)
      3, 4: b = {b[31], 8'(int'(a[30:23]) + int'($urandom_range(0, 6)) - 3), b[22:0]};
      5: begin
        a = {a[31], 7'd0, a[23:0]};
        b = {b[31], 7'd0, b[23:0]};
      end
      6: a = sp[$urandom_range(0, 5)];
      7: b = {b[31], a[30:3], b[2:0]};
      default: ;
    endcase
  endtask

  // Directed vector: accept at cycle 0, result must appear in cycle 3.
  task automatic run_vec(input int i);
    in_valid = 1'b1; x1 = vecs[i].x1; x2 = vecs[i].x2; op = vecs[i].op;
    in_tag = TAG_W'(i); out_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk($sformatf("vec%0d_early_valid", i), {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
    chk($sformatf("vec%0d_y", i), {32'd0, y}, {32'd0, vecs[i].y});
    chk($sformatf("vec%0d_ovf", i), {63'd0, ovf}, {63'd0, vecs[i].ovf});
    chk($sformatf("vec%0d_tag", i), {59'd0, out_tag}, 64'(i));
    @(posedge clk); #1;
  endtask

  bit acc, rdy, pending, did_rst;
  int nxt, first_full, n_full, n_acc;

  initial begin
    vecs[0]  = '{32'h3f800000, 32'h3f800000, 1'b0, 32'h40000000, 1'b0};
    vecs[1]  = '{32'h3f800000, 32'h33800000, 1'b0, 32'h3f800000, 1'b0};
    vecs[2]  = '{32'h3f800001, 32'h33800000, 1'b0, 32'h3f800002, 1'b0};
    vecs[3]  = '{32'h3f800000, 32'h3f800000, 1'b1, 32'h00000000, 1'b0};
    vecs[4]  = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0};
    vecs[5]  = '{32'h7f7fffff, 32'h7f7fffff, 1'b0, 32'h7f800000, 1'b1};
    vecs[6]  = '{32'h7f800000, 32'hff800000, 1'b0, 32'h7fc00000, 1'b0};
    vecs[7]  = '{32'h7f800000, 32'h3f800000, 1'b0, 32'h7f800000, 1'b0};
    vecs[8]  = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0};
    vecs[9]  = '{32'h00800000, 32'h00000001, 1'b1, 32'h007fffff, 1'b0};
    vecs[10] = '{32'h7fa00000, 32'h3f800000, 1'b0, 32'h7fc00000, 1'b0};
    vecs[11] = '{32'h40400000, 32'h3f800000, 1'b1, 32'h40000000, 1'b0};

    // Reset block
    rst = 1'b1; in_valid = 1'b0; x1 = '0; x2 = '0; op = 1'b0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_y", {32'd0, y}, 64'd0);
    chk("reset_ovf", {63'd0, ovf}, 64'd0);
    chk("reset_tag", {59'd0, out_tag}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 12; i++) run_vec(i);

    // Backpressure: tags 0..5 back to back, consumer stalled in cycles 2..7
    sb_en = 1'b1; popped = 0; nxt = 0; first_full = -1; n_full = 0;
    for (int c = 0; c < 60 && popped < 6; c++) begin
      out_ready = !(c >= 2 && c <= 7);
      in_valid = (nxt < 6);
      if (nxt < 6) begin
        x1 = vecs[nxt].x1; x2 = vecs[nxt].x2; op = vecs[nxt].op; in_tag = TAG_W'(nxt);
      end
      step(acc, rdy);
      if (acc) nxt++;
      if (!rdy) begin
        n_full++;
        if (first_full < 0) first_full = c;
      end
    end
    chk("bp_first_full_cycle", 64'(first_full), 64'd3);
    chk("bp_full_cycles", 64'(n_full), 64'd5);
    chk("bp_results_out", 64'(popped), 64'd6);
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Random traffic with a reset in the middle
    in_valid = 1'b0; n_acc = 0; pending = 1'b0; did_rst = 1'b0;
    for (int c = 0; c < 60000 && n_acc < 10000; c++) begin
      if (!did_rst && n_acc >= 5000) begin
        did_rst = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!pending) begin
            gen_op(x1, x2, op); in_tag = TAG_W'($urandom); pending = 1'b1;
          end
          in_valid = 1'b1;
          step(acc, rdy);
          if (acc) begin pending = 1'b0; n_acc++; end
        end
        chk("rst_pre_out_valid", {63'd0, out_valid}, 64'd1);
        rst = 1'b1; in_valid = 1'b0; pending = 1'b0;
        #1;
        chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_mid_y", {32'd0, y}, 64'd0);
        chk("rst_mid_tag", {59'd0, out_tag}, 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pending && $urandom_range(0, 4) != 0) begin
        gen_op(x1, x2, op); in_tag = TAG_W'($urandom); pending = 1'b1;
      end
      in_valid = pending;
      step(acc, rdy);
      if (acc) begin pending = 1'b0; n_acc++; end
    end
    chk("rand_accepted", 64'(n_acc), 64'd10000);

    // Drain
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) step(acc, rdy);
    step(acc, rdy);
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_out_valid", {63'd0, out_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
